// File: rtl/btn_event_sched.sv
// btn_event_sched: round-robin button event arbiter, FIFO and cursor/select executor
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   btn_vld[4:0]       one-cycle pulses: 0=up 1=down 2=left 3=right 4=select
//   cursor_x/cursor_y  current cursor position
//   sel_valid/sel_x/sel_y/sel_ready  select handshake to the game core
//   busy               any event pending, queued or executing
//   drop_cnt           saturating count of merged pulses
// Macro CURSOR_CLAMP_EN: cursor saturates at board edges instead of wrapping.
module btn_event_sched #(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int XW         = 3,
    parameter int YW         = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    btn_vld,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          sel_valid,
    output logic [XW-1:0] sel_x,
    output logic [YW-1:0] sel_y,
    input  logic          sel_ready,
    output logic          busy,
    output logic [7:0]    drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SEL_WAIT} state_t;

    state_t        state, state_nxt;
    logic [4:0]    pend;
    logic [2:0]    rr_ptr;
    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, can_push, merge;
    logic          gnt_vld;
    logic [2:0]    gnt;
    logic [3:0]    idx;
    logic [4:0]    gnt_oh;
    logic [2:0]    head;
    logic          x_min, x_max, y_min, y_max;
    logic [XW-1:0] x_dec, x_inc, x_nxt;
    logic [YW-1:0] y_dec, y_inc, y_nxt;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign pop      = (state == IDLE) && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign can_push = !full || pop;
    assign busy     = (pend != '0) || !empty || (state != IDLE);
    assign sel_valid = state == SEL_WAIT;

    // walk from the farthest candidate down so the closest to rr_ptr wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = 4; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            idx = idx >= 4'd5 ? idx - 4'd5 : idx;
            if (pend[idx[2:0]] && can_push) begin
                gnt_vld = 1'b1;
                gnt     = idx[2:0];
            end
        end
        gnt_oh = gnt_vld ? 5'b00001 << gnt : 5'b00000;
    end

    assign merge = |(btn_vld & pend & ~gnt_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            pend <= (pend & ~gnt_oh) | btn_vld;
            if (gnt_vld)
                rr_ptr <= gnt == 3'd4 ? 3'd0 : gnt + 3'd1;
            if (merge && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld)
            fifo_mem[wr_ptr[AW-1:0]] <= gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (gnt_vld)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign x_min = cursor_x == '0;
    assign x_max = cursor_x == XW'(COLS - 1);
    assign y_min = cursor_y == '0;
    assign y_max = cursor_y == YW'(ROWS - 1);

`ifdef CURSOR_CLAMP_EN
    assign x_dec = x_min ? cursor_x : cursor_x - 1'b1;
    assign x_inc = x_max ? cursor_x : cursor_x + 1'b1;
    assign y_dec = y_min ? cursor_y : cursor_y - 1'b1;
    assign y_inc = y_max ? cursor_y : cursor_y + 1'b1;
`else
    // wrap on the board size, not on the register width
    assign x_dec = x_min ? XW'(COLS - 1) : cursor_x - 1'b1;
    assign x_inc = x_max ? '0 : cursor_x + 1'b1;
    assign y_dec = y_min ? YW'(ROWS - 1) : cursor_y - 1'b1;
    assign y_inc = y_max ? '0 : cursor_y + 1'b1;
`endif

    always_comb begin
        x_nxt = head == 3'd2 ? x_dec : head == 3'd3 ? x_inc : cursor_x;
        y_nxt = head == 3'd0 ? y_dec : head == 3'd1 ? y_inc : cursor_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x <= '0;
            cursor_y <= '0;
            sel_x    <= '0;
            sel_y    <= '0;
        end else if (pop) begin
            cursor_x <= x_nxt;
            cursor_y <= y_nxt;
            if (head == 3'd4) begin
                sel_x <= cursor_x;
                sel_y <= cursor_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (pop && head == 3'd4) ? SEL_WAIT : IDLE;
        else
            state_nxt = sel_ready ? IDLE : SEL_WAIT;
    end
endmodule

// File: tb/tb_btn_event_sched.sv
// tb_btn_event_sched: scoreboard bench for btn_event_sched
module tb_btn_event_sched;
    localparam int COLS = 8;
    localparam int ROWS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_vld = '0;
    logic       sel_ready = 1'b0;
    logic [2:0] cursor_x, cursor_y, sel_x, sel_y;
    logic       sel_valid, busy;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    int mx = 0;
    int my = 0;
    logic [6:0] sb [$];
    logic [6:0] got, exp_e;
    logic [2:0] px = '0;
    logic [2:0] py = '0;
    logic       psv = 1'b0;
    logic       hit;

    btn_event_sched #(.COLS(COLS), .ROWS(ROWS), .XW(3), .YW(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .btn_vld(btn_vld),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y), .sel_ready(sel_ready),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // observed events: cursor change {0,x,y} or rising sel_valid {1,sel_x,sel_y}
    always @(negedge clk) begin
        hit = 1'b0;
        if (rst) begin
            px = '0;
            py = '0;
            psv = 1'b0;
        end else begin
            if (sel_valid && !psv) begin
                hit = 1'b1;
                got = {1'b1, sel_x, sel_y};
            end else if (cursor_x !== px || cursor_y !== py) begin
                hit = 1'b1;
                got = {1'b0, cursor_x, cursor_y};
            end
            if (hit) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_event: got=%h expected=none", got);
                end else begin
                    exp_e = sb.pop_front();
                    if (got !== exp_e) begin
                        errors++;
                        $display("FAIL sb_event: got=%h expected=%h", got, exp_e);
                    end
                end
            end
            px = cursor_x;
            py = cursor_y;
            psv = sel_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] v);
        btn_vld = v;
        tick();
        btn_vld = '0;
    endtask

    task automatic expect_move(input int code);
        int nx = mx;
        int ny = my;
`ifdef CURSOR_CLAMP_EN
        if (code == 0 && my > 0) ny = my - 1;
        if (code == 1 && my < ROWS - 1) ny = my + 1;
        if (code == 2 && mx > 0) nx = mx - 1;
        if (code == 3 && mx < COLS - 1) nx = mx + 1;
`else
        if (code == 0) ny = (my + ROWS - 1) % ROWS;
        if (code == 1) ny = (my + 1) % ROWS;
        if (code == 2) nx = (mx + COLS - 1) % COLS;
        if (code == 3) nx = (mx + 1) % COLS;
`endif
        if (nx != mx || ny != my)
            sb.push_back({1'b0, 3'(nx), 3'(ny)});
        mx = nx;
        my = ny;
    endtask

    task automatic expect_sel();
        sb.push_back({1'b1, 3'(mx), 3'(my)});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        btn_vld = '0;
        sel_ready = 1'b0;
        tick();
        tick();
        sb.delete();
        rst = 1'b0;
        mx = 0;
        my = 0;
    endtask

    task automatic wait_sel();
        int n = 0;
        while (!sel_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_sel: sel_valid=%b expected=1 within 20 cycles", sel_valid);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: busy=%b pending_expected=%0d expected busy=0 and 0", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cursor_x, cursor_y, sel_valid, sel_x, sel_y, busy, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: x=%0d y=%0d sv=%b sx=%0d sy=%0d busy=%b drop=%0d expected all 0",
                     cursor_x, cursor_y, sel_valid, sel_x, sel_y, busy, drop_cnt);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        expect_move(3);
        pulse(5'b01000);
        checks++;
        if (cursor_x !== 3'd0) begin
            errors++;
            $display("FAIL latency_c1: cursor_x=%0d expected=0", cursor_x);
        end
        tick();
        checks++;
        if (cursor_x !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_c2: cursor_x=%0d busy=%b expected 0 and 1", cursor_x, busy);
        end
        tick();
        checks++;
        if (cursor_x !== 3'd1 || cursor_y !== 3'd0) begin
            errors++;
            $display("FAIL latency_c3: cursor=(%0d,%0d) expected=(1,0)", cursor_x, cursor_y);
        end
        drain();
    endtask

    task automatic test_edges();
        logic [4:0] seq [4];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 5; c++)
                if (seq[i][c]) expect_move(c);
            pulse(seq[i]);
            drain();
            checks++;
            if (cursor_x !== 3'(mx) || cursor_y !== 3'(my)) begin
                errors++;
                $display("FAIL edge_%0d: cursor=(%0d,%0d) expected=(%0d,%0d)", i, cursor_x, cursor_y, mx, my);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        expect_move(3);
        expect_sel();
        pulse(5'b11000);
        wait_sel();
        checks++;
        if (sel_x !== 3'd1 || sel_y !== 3'd0 || cursor_x !== 3'd1) begin
            errors++;
            $display("FAIL rr_order: sel=(%0d,%0d) cursor_x=%0d expected sel=(1,0) cursor_x=1", sel_x, sel_y, cursor_x);
        end
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        drain();
    endtask

    task automatic test_sel_hold();
        apply_reset();
        expect_sel();
        pulse(5'b10000);
        wait_sel();
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 2 || i == 4) begin
                expect_move(3);
                btn_vld = 5'b01000;
            end
            tick();
            btn_vld = '0;
            checks++;
            if ({sel_valid, sel_x, sel_y, cursor_x} !== {1'b1, 3'd0, 3'd0, 3'd0}) begin
                errors++;
                $display("FAIL sel_hold_%0d: sv=%b sel=(%0d,%0d) cursor_x=%0d expected sv=1 sel=(0,0) cursor_x=0",
                         i, sel_valid, sel_x, sel_y, cursor_x);
            end
        end
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_release: sel_valid=%b expected=0", sel_valid);
        end
        tick();
        tick();
        checks++;
        if (cursor_x !== 3'd2) begin
            errors++;
            $display("FAIL sel_resume_2: cursor_x=%0d expected=2", cursor_x);
        end
        tick();
        checks++;
        if (cursor_x !== 3'd3) begin
            errors++;
            $display("FAIL sel_resume_3: cursor_x=%0d expected=3", cursor_x);
        end
        drain();
    endtask

    task automatic test_drop();
        apply_reset();
        expect_sel();
        pulse(5'b10000);
        wait_sel();
        for (int i = 0; i < 4; i++) begin
            expect_move(3);
            pulse(5'b01000);
            tick();
        end
        expect_move(0);
        pulse(5'b00001);
        pulse(5'b00001);
        pulse(5'b00001);
        checks++;
        if (drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL drop_two: drop_cnt=%0d expected=2", drop_cnt);
        end
        expect_move(3);
        pulse(5'b01000);
        pulse(5'b01001);
        checks++;
        if (drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL drop_multi: drop_cnt=%0d expected=3", drop_cnt);
        end
        btn_vld = 5'b00001;
        for (int i = 0; i < 260; i++) tick();
        btn_vld = '0;
        tick();
        checks++;
        if (drop_cnt !== 8'd255 || sel_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_sat: drop_cnt=%0d sv=%b busy=%b expected 255 1 1", drop_cnt, sel_valid, busy);
        end
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        drain();
        checks++;
        if (cursor_x !== 3'(mx) || cursor_y !== 3'(my) || drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_final: cursor=(%0d,%0d) drop=%0d expected=(%0d,%0d) 255",
                     cursor_x, cursor_y, drop_cnt, mx, my);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        expect_sel();
        pulse(5'b10000);
        wait_sel();
        pulse(5'b01000);
        tick();
        pulse(5'b00100);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({sel_valid, busy, cursor_x, cursor_y} !== '0) begin
            errors++;
            $display("FAIL reset_mid: sv=%b busy=%b cursor=(%0d,%0d) expected all 0", sel_valid, busy, cursor_x, cursor_y);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if ({sel_valid, busy, cursor_x, cursor_y} !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_quiet: sv=%b busy=%b cursor=(%0d,%0d) sb=%0d expected all 0",
                     sel_valid, busy, cursor_x, cursor_y, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_edges();
        test_round_robin();
        test_sel_hold();
        test_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
